instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Instruction prefetch queue between the CPU fetch stage and the instruction port of the SPI
//  memory controller. Drives sequential word addresses to the controller and captures each
//  returned word on the controller's 1-cycle ready pulse. Buffers up to DEPTH {pc,instr} pairs
//  for the core and flushes/redirects on branches, dropping the stale in-flight fetch.
// PARAMETERS
//  DEPTH     4             queue entries; power of 2, >= 2
//  RESET_PC  32'h80000000  first fetch address after reset (flash region)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  redirect       in   1   1-cycle pulse: flush queue, restart fetch at redirect_pc
//  redirect_pc    in   32  new fetch address; bits[1:0] ignored and forced to 0
//  fetch_ready    in   1   core accepts head entry this cycle
//  fetch_valid    out  1   head entry valid (queue not empty)
//  fetch_pc       out  32  address of head instruction
//  fetch_instr    out  32  head instruction word, already byte-swapped by controller
//  fifo_level     out  clog2(DEPTH)+1  number of valid entries
//  instr_addr     out  32  address presented to controller (word aligned)
//  instr_data     in   32  word from controller, valid only while instr_ready=1
//  instr_ready    in   1   1-cycle pulse: controller completed a fetch of the address it latched
// BEHAVIOUR
//  Reset: instr_addr=RESET_PC, queue empty, fetch_valid=0, fetch_pc=0, fetch_instr=0,
//   fifo_level=0, discard flag=0, state=RUN.
//  Outputs fetch_valid/fetch_pc/fetch_instr are combinational from queue head; all state registered.
//  Controller behaviour relied on: latches instr_addr when it starts a fetch; refetches the
//   same address after every ready pulse while instr_addr is unchanged; data access has priority.
//  Accept (no redirect, instr_ready=1, state=RUN):
//   - queue not full, or full with pop same cycle: push {instr_addr, instr_data};
//     instr_addr <= instr_addr + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
//   - queue full, no pop: word dropped, instr_addr held (controller refetches it later).
//  Pop: fetch_ready & fetch_valid removes head; fetch_ready while empty ignored.
//  Simultaneous push+pop: level unchanged; push+pop with level==1 is legal, new word becomes head.
//  States: RUN (accepting), DISCARD (next instr_ready pulse is stale, drop it).
//   RUN -> DISCARD: redirect while instr_ready=0.
//   RUN -> RUN: redirect while instr_ready=1 (that pulse is the stale one; dropped, no flag).
//   DISCARD -> RUN: on instr_ready pulse; word dropped, instr_addr NOT advanced.
//   DISCARD + redirect: stay DISCARD, instr_addr <= new redirect_pc.
//  Redirect (any state): queue emptied same edge, fifo_level=0, fetch_valid=0 next cycle;
//   instr_addr <= {redirect_pc[31:2],2'b00}; concurrent pop and push ignored.
//  A discarded pulse may be a correct word (controller was busy with data and had not
//   started the old fetch); cost is one refetch only, never wrong data.
//  Reset mid-operation: immediate return to reset values; pending pulse not tracked.
// TESTING
//  Reset, no stalls, controller model 40-cycle fetches -> pc 0x80000000,04,08,0C delivered in order with matching words.
//  Core stalls (fetch_ready=0) until level==DEPTH -> instr_addr holds 0x80000010, further pulses dropped, no overwrite; release -> resumes 0x80000010.
//  Redirect to 0x80000123 mid-fetch of 0x80000008 -> stale word dropped, next head pc=0x80000120, level was 0 the cycle after redirect.
//  Redirect coincident with instr_ready -> pulse dropped, state RUN, next pulse accepted as pc=redirect target.
//  Full queue with push+pop same cycle -> level stays DEPTH, order preserved; redirect+fetch_ready same cycle -> queue empty.
//  instr_addr=0xFFFFFFFC accepted -> instr_addr wraps to 0x00000000; async reset mid-fetch -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/instr_prefetch_if.sv
// Prefetch-queue bus bundle: core-side fetch port plus the controller-side
// instruction fetch port.
//   slave  : the prefetch queue (drives fetch_* head outputs and instr_addr)
//   master : the environment (core + SPI controller)
// Signals:
//   redirect/redirect_pc        flush and restart fetch at a new pc
//   fetch_ready/valid/pc/instr  head-of-queue handshake toward the core
//   fifo_level                  number of buffered entries
//   instr_addr/data/ready       word address out, word + 1-cycle ready pulse in
interface instr_prefetch_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_instr;
  logic [LW-1:0] fifo_level;
  logic [31:0]   instr_addr;
  logic [31:0]   instr_data;
  logic          instr_ready;

  modport master (
    output redirect, redirect_pc, fetch_ready, instr_data, instr_ready,
    input  fetch_valid, fetch_pc, fetch_instr, fifo_level, instr_addr
  );

  modport slave (
    input  redirect, redirect_pc, fetch_ready, instr_data, instr_ready,
    output fetch_valid, fetch_pc, fetch_instr, fifo_level, instr_addr
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue between the CPU fetch stage and the SPI memory
// controller's instruction port. Presents sequential word addresses, captures
// each returned word on the controller's ready pulse and buffers up to DEPTH
// {pc,instr} pairs. A redirect flushes the queue and restarts fetching; the
// fetch already in flight at that moment is dropped when it returns.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_prefetch_if.slave (see interface header)
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic             clk,
  input logic             rst_n,
  instr_prefetch_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // DISCARD: the next ready pulse belongs to a fetch issued before a redirect.
  typedef enum logic {RUN, DISCARD} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e                state_q, state_d;
  entry_t [DEPTH-1:0]    mem_q, mem_d;
  logic   [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic   [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic   [AW:0]         level_q, level_d;
  logic   [31:0]         addr_q, addr_d;
  logic                  empty, full, pop, push;

  // Low address bits are forced to zero, so they are intentionally dropped.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    addr_d   = addr_q;
    pop      = 1'b0;
    push     = 1'b0;
    if (bus.redirect) begin
      // Flush wins over any same-cycle pop or push.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      addr_d   = {bus.redirect_pc[31:2], 2'b00};
      // A pulse arriving with the redirect is itself the stale one, so only
      // an outstanding (not yet returned) fetch needs to be flagged.
      if (state_q == RUN && !bus.instr_ready) state_d = DISCARD;
    end else begin
      pop = bus.fetch_ready && !empty;
      if (bus.instr_ready) begin
        if (state_q == DISCARD) state_d = RUN;
        // Full without pop: word dropped, address held so it is refetched.
        else if (!full || pop) push = 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q].pc    = addr_q;
        mem_d[wr_ptr_q].instr = bus.instr_data;
        wr_ptr_d              = wr_ptr_q + AW'(1);
        addr_d                = addr_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= RESET_PC;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
    end
  end

  // Head outputs read as zero while empty.
  assign bus.fetch_valid = !empty;
  assign bus.fetch_pc    = empty ? 32'h0 : mem_q[rd_ptr_q].pc;
  assign bus.fetch_instr = empty ? 32'h0 : mem_q[rd_ptr_q].instr;
  assign bus.fifo_level  = level_q;
  assign bus.instr_addr  = addr_q;
endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [2:0]  LVL_FULL = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of delivered pairs, next fetch address, stale flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_addr;
  bit          m_stale;

  // SPI controller model: latches instr_addr at fetch start, pulses after lat cycles.
  bit          ctl_active;
  logic [31:0] ctl_addr;
  int          ctl_timer, ctl_idle, ctl_lat, ctl_gap;
  bit          ctl_rand;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic set_ctl_out();
    bus.instr_ready = ctl_active && (ctl_timer == 0);
    bus.instr_data  = bus.instr_ready ? word_of(ctl_addr) : $urandom;
  endtask

  task automatic ctl_try_start();
    if (!ctl_active && ctl_idle == 0) begin
      ctl_active = 1;
      ctl_addr   = bus.instr_addr;
      if (ctl_rand) ctl_lat = $urandom_range(2, 6);
      ctl_timer  = ctl_lat - 1;
    end
  endtask

  task automatic model_update();
    bit popped, pushed;
    ent_t e;
    if (bus.redirect) begin
      mq.delete();
      m_stale = m_stale || !bus.instr_ready;
      m_addr  = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      popped = bus.fetch_ready && mq.size() > 0;
      pushed = 0;
      if (bus.instr_ready) begin
        if (m_stale) m_stale = 0;
        else if (mq.size() < DEPTH || popped) pushed = 1;
      end
      if (popped) void'(mq.pop_front());
      if (pushed) begin
        e.pc = m_addr; e.instr = bus.instr_data;
        mq.push_back(e);
        m_addr = m_addr + 32'd4;
      end
    end
  endtask

  // One clock: model sees this cycle's inputs, then DUT and controller advance.
  task automatic step();
    model_update();
    @(posedge clk); #1;
    bus.redirect = 0;
    if (bus.instr_ready) begin
      ctl_active = 0;
      ctl_idle   = ctl_rand ? $urandom_range(0, ctl_gap) : ctl_gap;
    end else if (ctl_active) ctl_timer--;
    else if (ctl_idle > 0) ctl_idle--;
    ctl_try_start();
    set_ctl_out();
  endtask

  task automatic do_reset(input int lat, input int gap, input bit rnd);
    rst_n = 0;
    bus.redirect = 0; bus.redirect_pc = '0; bus.fetch_ready = 0;
    bus.instr_ready = 0; bus.instr_data = '0;
    ctl_active = 0; ctl_idle = 0; ctl_lat = lat; ctl_gap = gap; ctl_rand = rnd;
    mq.delete(); m_addr = RESET_PC; m_stale = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    ctl_try_start();
    set_ctl_out();
  endtask

  task automatic test_reset();
    do_reset(40, 0, 0);
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", bus.fetch_pc); end
    n_cmp++; if (bus.fetch_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", bus.fetch_instr); end
    n_cmp++; if (bus.fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
    n_cmp++; if (bus.instr_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", bus.instr_addr, RESET_PC); end
  endtask

  task automatic test_in_order();
    logic [31:0] pc;
    int k;
    k = 0;
    do_reset(40, 0, 0);
    bus.fetch_ready = 1;
    for (int cyc = 0; cyc < 400 && k < 4; cyc++) begin
      if (bus.fetch_valid) begin
        pc = RESET_PC + 32'(4 * k);
        n_cmp++;
        if (bus.fetch_pc !== pc || bus.fetch_instr !== word_of(pc)) begin
          n_bad++; $display("FAIL in_order[%0d]: got pc=%h instr=%h want pc=%h instr=%h", k, bus.fetch_pc, bus.fetch_instr, pc, word_of(pc));
        end
        k++;
      end
      step();
    end
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL in_order_count: got %0d want 4", k); end
  endtask

  task automatic test_stall();
    int cyc;
    logic [31:0] pc;
    do_reset(40, 0, 0);
    cyc = 0;
    while (bus.fifo_level !== LVL_FULL && cyc < 400) begin step(); cyc++; end
    n_cmp++; if (bus.fifo_level !== LVL_FULL) begin n_bad++; $display("FAIL stall_fill: got level %0d want %0d", bus.fifo_level, LVL_FULL); end
    n_cmp++; if (bus.instr_addr !== 32'h8000_0010) begin n_bad++; $display("FAIL stall_addr: got %h want 80000010", bus.instr_addr); end
    repeat (100) step();
    n_cmp++;
    if (bus.fifo_level !== LVL_FULL || bus.instr_addr !== 32'h8000_0010 || bus.fetch_pc !== RESET_PC || bus.fetch_instr !== word_of(RESET_PC)) begin
      n_bad++; $display("FAIL stall_hold: got level=%0d addr=%h pc=%h instr=%h want level=4 addr=80000010 pc=80000000 instr=%h", bus.fifo_level, bus.instr_addr, bus.fetch_pc, bus.fetch_instr, word_of(RESET_PC));
    end
    bus.fetch_ready = 1;
    for (int k = 0; k < 4; k++) begin
      pc = RESET_PC + 32'(4 * k);
      n_cmp++; if (bus.fetch_pc !== pc) begin n_bad++; $display("FAIL stall_drain[%0d]: got pc=%h want %h", k, bus.fetch_pc, pc); end
      step();
    end
    cyc = 0;
    while (!bus.fetch_valid && cyc < 200) begin step(); cyc++; end
    n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h8000_0010) begin n_bad++; $display("FAIL stall_resume: got valid=%b pc=%h want 1 80000010", bus.fetch_valid, bus.fetch_pc); end
    bus.fetch_ready = 0;
  endtask

  task automatic test_redirect_mid();
    int cyc;
    do_reset(40, 0, 0);
    bus.fetch_ready = 1;
    cyc = 0;
    while (!(ctl_active && ctl_addr == 32'h8000_0008 && ctl_timer <= 20) && cyc < 400) begin step(); cyc++; end
    n_cmp++; if (ctl_addr !== 32'h8000_0008) begin n_bad++; $display("FAIL redir_setup: got fetch addr %h want 80000008", ctl_addr); end
    bus.redirect = 1; bus.redirect_pc = 32'h8000_0123;
    step();
    n_cmp++;
    if (bus.fifo_level !== 3'd0 || bus.fetch_valid !== 1'b0 || bus.instr_addr !== 32'h8000_0120) begin
      n_bad++; $display("FAIL redir_flush: got level=%0d valid=%b addr=%h want 0 0 80000120", bus.fifo_level, bus.fetch_valid, bus.instr_addr);
    end
    cyc = 0;
    while (!bus.fetch_valid && cyc < 200) begin step(); cyc++; end
    n_cmp++;
    if (bus.fetch_pc !== 32'h8000_0120 || bus.fetch_instr !== word_of(32'h8000_0120)) begin
      n_bad++; $display("FAIL redir_head: got pc=%h instr=%h want 80000120 %h", bus.fetch_pc, bus.fetch_instr, word_of(32'h8000_0120));
    end
  endtask

  task automatic test_redirect_coincident();
    int cyc;
    do_reset(10, 0, 0);
    bus.fetch_ready = 1;
    cyc = 0;
    while (!(bus.instr_ready && ctl_addr == 32'h8000_0004) && cyc < 100) begin step(); cyc++; end
    n_cmp++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL coinc_setup: got ready=%b want 1", bus.instr_ready); end
    bus.redirect = 1; bus.redirect_pc = 32'h8000_0040;
    step();
    n_cmp++;
    if (bus.fifo_level !== 3'd0 || bus.instr_addr !== 32'h8000_0040) begin
      n_bad++; $display("FAIL coinc_flush: got level=%0d addr=%h want 0 80000040", bus.fifo_level, bus.instr_addr);
    end
    cyc = 0;
    while (!bus.fetch_valid && cyc < 30) begin step(); cyc++; end
    n_cmp++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h8000_0040 || cyc > 12) begin
      n_bad++; $display("FAIL coinc_next: got valid=%b pc=%h after %0d cycles want 1 80000040 within 12", bus.fetch_valid, bus.fetch_pc, cyc);
    end
    bus.fetch_ready = 0;
  endtask

  task automatic test_full_pushpop();
    int cyc;
    do_reset(8, 0, 0);
    cyc = 0;
    while (bus.fifo_level !== LVL_FULL && cyc < 200) begin step(); cyc++; end
    cyc = 0;
    while (!bus.instr_ready && cyc < 50) begin step(); cyc++; end
    n_cmp++; if (bus.instr_ready !== 1'b1 || bus.fifo_level !== LVL_FULL) begin n_bad++; $display("FAIL full_setup: got ready=%b level=%0d want 1 4", bus.instr_ready, bus.fifo_level); end
    bus.fetch_ready = 1;
    step();
    bus.fetch_ready = 0;
    n_cmp++;
    if (bus.fifo_level !== LVL_FULL || bus.fetch_pc !== 32'h8000_0004 || bus.instr_addr !== 32'h8000_0014) begin
      n_bad++; $display("FAIL full_pushpop: got level=%0d pc=%h addr=%h want 4 80000004 80000014", bus.fifo_level, bus.fetch_pc, bus.instr_addr);
    end
    bus.fetch_ready = 1;
    step();
    n_cmp++;
    if (bus.fifo_level !== 3'd3 || bus.fetch_pc !== 32'h8000_0008) begin
      n_bad++; $display("FAIL full_pop: got level=%0d pc=%h want 3 80000008", bus.fifo_level, bus.fetch_pc);
    end
    bus.redirect = 1; bus.redirect_pc = 32'h9000_0000;
    step();
    n_cmp++;
    if (bus.fifo_level !== 3'd0 || bus.fetch_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_pop: got level=%0d valid=%b want 0 0", bus.fifo_level, bus.fetch_valid);
    end
    bus.fetch_ready = 0;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset(6, 0, 0);
    bus.redirect = 1; bus.redirect_pc = 32'hFFFF_FFFE;
    step();
    n_cmp++; if (bus.instr_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_align: got %h want fffffffc", bus.instr_addr); end
    cyc = 0;
    while (bus.fifo_level !== 3'd1 && cyc < 100) begin step(); cyc++; end
    n_cmp++;
    if (bus.fetch_pc !== 32'hFFFF_FFFC || bus.fetch_instr !== word_of(32'hFFFF_FFFC) || bus.instr_addr !== 32'h0) begin
      n_bad++; $display("FAIL wrap_addr: got pc=%h instr=%h addr=%h want fffffffc %h 00000000", bus.fetch_pc, bus.fetch_instr, bus.instr_addr, word_of(32'hFFFF_FFFC));
    end
    cyc = 0;
    while (bus.fifo_level !== 3'd2 && cyc < 100) begin step(); cyc++; end
    bus.fetch_ready = 1;
    step();
    bus.fetch_ready = 0;
    n_cmp++;
    if (bus.fetch_pc !== 32'h0 || bus.fetch_instr !== word_of(32'h0)) begin
      n_bad++; $display("FAIL wrap_next: got pc=%h instr=%h want 00000000 %h", bus.fetch_pc, bus.fetch_instr, word_of(32'h0));
    end
  endtask

  task automatic test_async_reset();
    do_reset(20, 0, 0);
    repeat (50) step();
    n_cmp++; if (bus.fifo_level !== 3'(mq.size())) begin n_bad++; $display("FAIL areset_pre: got level=%0d want %0d", bus.fifo_level, mq.size()); end
    #3;
    rst_n = 0;
    #1;
    n_cmp++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_pc !== 32'h0 || bus.fetch_instr !== 32'h0 || bus.fifo_level !== 3'd0 || bus.instr_addr !== RESET_PC) begin
      n_bad++; $display("FAIL areset: got valid=%b pc=%h instr=%h level=%0d addr=%h want 0 0 0 0 %h", bus.fetch_valid, bus.fetch_pc, bus.fetch_instr, bus.fifo_level, bus.instr_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] epc, ein;
    bit          slow;
    do_reset(4, 3, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      slow = ((cyc / 300) % 2) == 1;
      bus.fetch_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        bus.redirect = 1;
        bus.redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      step();
      epc = (mq.size() > 0) ? mq[0].pc : 32'h0;
      ein = (mq.size() > 0) ? mq[0].instr : 32'h0;
      n_cmp++;
      if (bus.fetch_valid !== (mq.size() > 0) || bus.fetch_pc !== epc || bus.fetch_instr !== ein ||
          bus.fifo_level !== 3'(mq.size()) || bus.instr_addr !== m_addr) begin
        n_bad++;
        $display("FAIL random@%0d: got v=%b pc=%h in=%h lvl=%0d addr=%h want v=%b pc=%h in=%h lvl=%0d addr=%h",
                 cyc, bus.fetch_valid, bus.fetch_pc, bus.fetch_instr, bus.fifo_level, bus.instr_addr,
                 mq.size() > 0, epc, ein, mq.size(), m_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_stall();
    test_redirect_mid();
    test_redirect_coincident();
    test_full_pushpop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
